alu_cc_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational Y86-64 ALU (2-bit control, overflow flag).
- Adds a valid/ready handshake with backpressure, a configurable pipeline depth, and an architectural condition-code register (ZF, SF, OF).
- Adds a Y86 condition evaluator (cnd) for cmovXX/jXX.
- Sits between the decode/register-read stage and the execute-to-memory boundary of the processor.

---
 rtl/alu_cc_pipe.sv | 150 +++++++++++++++
 tb/tb_alu_cc_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cc_pipe.sv
// Pipelined Y86-64 ALU with valid/ready handshake, configurable depth,
// a ZF/SF/OF condition-code register and a cmovXX/jXX condition evaluator.
module alu_cc_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ans,
  output logic             overflow,
  input  logic [2:0]       ifun,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             cnd
);

  localparam int LAST = STAGES - 1;

  logic [WIDTH-1:0]  res;
  logic              res_ovf;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] ovf_q, ovf_d;
  logic [STAGES-1:0] scc_q, scc_d;
  logic [STAGES-1:0] slot_open;
  logic [WIDTH-1:0]  ans_q [STAGES];
  logic [WIDTH-1:0]  ans_d [STAGES];

  logic zf_q, zf_d;
  logic sf_q, sf_d;
  logic of_q, of_d;
  logic retire;

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    case (control)
      2'b00: begin
        res     = a + b;
        res_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      2'b01: begin
        res     = a - b;
        res_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      2'b10:   res = a & b;
      default: res = a ^ b;
    endcase
  end

  // A slot can take new content when it is empty or its occupant moves on;
  // the chain runs from out_ready back to the first slot with no skid buffer.
  always_comb begin : pipe_next
    logic chain;
    slot_open = '0;
    chain     = out_ready;
    for (int k = LAST; k >= 0; k--) begin
      slot_open[k] = ~vld_q[k] | chain;
      chain        = slot_open[k];
    end

    vld_d = vld_q;
    ovf_d = ovf_q;
    scc_d = scc_q;
    ans_d = ans_q;
    if (slot_open[0]) begin
      vld_d[0] = in_valid;
      ans_d[0] = res;
      ovf_d[0] = res_ovf;
      scc_d[0] = set_cc;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (slot_open[k]) begin
        vld_d[k] = vld_q[k-1];
        ans_d[k] = ans_q[k-1];
        ovf_d[k] = ovf_q[k-1];
        scc_d[k] = scc_q[k-1];
      end
    end
  end

  assign retire = vld_q[LAST] & out_ready;

  always_comb begin
    zf_d = zf_q;
    sf_d = sf_q;
    of_d = of_q;
    if (retire && scc_q[LAST]) begin
      zf_d = (ans_q[LAST] == '0);
      sf_d = ans_q[LAST][WIDTH-1];
      of_d = ovf_q[LAST];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      ovf_q <= '0;
      scc_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        ans_q[k] <= '0;
      end
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      ovf_q <= ovf_d;
      scc_q <= scc_d;
      for (int k = 0; k < STAGES; k++) begin
        ans_q[k] <= ans_d[k];
      end
      zf_q <= zf_d;
      sf_q <= sf_d;
      of_q <= of_d;
    end
  end

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      3'd0: cnd = 1'b1;
      3'd1: cnd = (sf_q ^ of_q) | zf_q;
      3'd2: cnd = sf_q ^ of_q;
      3'd3: cnd = zf_q;
      3'd4: cnd = ~zf_q;
      3'd5: cnd = ~(sf_q ^ of_q);
      3'd6: cnd = ~(sf_q ^ of_q) & ~zf_q;
      default: cnd = 1'b0;
    endcase
  end

  assign in_ready  = slot_open[0];
  assign out_valid = vld_q[LAST];
  assign ans       = ans_q[LAST];
  assign overflow  = ovf_q[LAST];
  assign zf        = zf_q;
  assign sf        = sf_q;
  assign of        = of_q;

endmodule

// File: tb/tb_alu_cc_pipe.sv
// Scoreboard bench for alu_cc_pipe: a 64-bit/2-stage instance for the main
// scenarios plus 8-bit instances with 1 and 4 stages for latency checks.
module tb_alu_cc_pipe;

  localparam int W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, set_cc, out_valid, out_ready;
  logic         overflow, zf, sf, of, cnd;
  logic [1:0]   control;
  logic [W-1:0] a, b, ans;
  logic [2:0]   ifun;

  logic       sm_valid, sm_ordy, sm_scc;
  logic [1:0] sm_ctl;
  logic [7:0] sm_a, sm_b;
  logic [2:0] sm_ifun;
  logic       s1_ready, s1_ovalid, s1_ovf, s1_zf, s1_sf, s1_of, s1_cnd;
  logic       s4_ready, s4_ovalid, s4_ovf, s4_zf, s4_sf, s4_of, s4_cnd;
  logic [7:0] s1_ans, s4_ans;

  alu_cc_pipe #(.WIDTH(64), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .control(control), .a(a), .b(b), .set_cc(set_cc),
    .out_valid(out_valid), .out_ready(out_ready), .ans(ans), .overflow(overflow),
    .ifun(ifun), .zf(zf), .sf(sf), .of(of), .cnd(cnd)
  );

  alu_cc_pipe #(.WIDTH(8), .STAGES(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(sm_valid), .in_ready(s1_ready),
    .control(sm_ctl), .a(sm_a), .b(sm_b), .set_cc(sm_scc),
    .out_valid(s1_ovalid), .out_ready(sm_ordy), .ans(s1_ans), .overflow(s1_ovf),
    .ifun(sm_ifun), .zf(s1_zf), .sf(s1_sf), .of(s1_of), .cnd(s1_cnd)
  );

  alu_cc_pipe #(.WIDTH(8), .STAGES(4)) dut_s4 (
    .clk(clk), .rst(rst), .in_valid(sm_valid), .in_ready(s4_ready),
    .control(sm_ctl), .a(sm_a), .b(sm_b), .set_cc(sm_scc),
    .out_valid(s4_ovalid), .out_ready(sm_ordy), .ans(s4_ans), .overflow(s4_ovf),
    .ifun(sm_ifun), .zf(s4_zf), .sf(s4_sf), .of(s4_of), .cnd(s4_cnd)
  );

  typedef struct {
    logic [63:0] ans;
    logic        ovf;
    logic        sc;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [63:0] ans;
    logic        ovf;
    int          cyc;
  } got_t;

  typedef struct {
    logic        ov;
    logic [63:0] ans;
    logic        ovf;
    logic        ir;
    logic        zf;
    logic        sf;
    logic        of;
    logic        cnd;
  } log_t;

  exp_t exp_q[$];
  got_t got_q[$];
  log_t logs[0:2047];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  // Reference arithmetic on a 65-bit sign-extended datapath; overflow is a
  // disagreement between the two top bits of the wide result.
  function automatic logic [64:0] model(input logic [1:0] c, input logic [63:0] x,
                                        input logic [63:0] y);
    logic [64:0] w;
    logic [64:0] r;
    w = '0;
    r = '0;
    case (c)
      2'd0: begin w = {x[63], x} + {y[63], y}; r = {w[64] ^ w[63], w[63:0]}; end
      2'd1: begin w = {x[63], x} - {y[63], y}; r = {w[64] ^ w[63], w[63:0]}; end
      2'd2: r = {1'b0, x & y};
      default: r = {1'b0, x ^ y};
    endcase
    return r;
  endfunction

  // Drives one cycle, logs outputs at the falling edge and feeds the queues.
  task automatic step(input logic v, input logic [1:0] c, input logic [63:0] x,
                      input logic [63:0] y, input logic sc, input logic ordy,
                      output logic acc);
    logic [64:0] m;
    in_valid  = v;
    control   = c;
    a         = x;
    b         = y;
    set_cc    = sc;
    out_ready = ordy;
    @(negedge clk);
    logs[cyc] = '{out_valid, ans, overflow, in_ready, zf, sf, of, cnd};
    acc = in_valid && in_ready;
    if (acc) begin
      m = model(c, x, y);
      exp_q.push_back('{m[63:0], m[64], sc, cyc});
    end
    if (out_valid && out_ready) got_q.push_back('{ans, overflow, cyc});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (ans !== 64'd0) begin bad++; $display("FAIL reset_ans got=%h want=0", ans); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    total++; if ({zf, sf, of} !== 3'b100) begin bad++; $display("FAIL reset_cc got=%b want=100", {zf, sf, of}); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    ifun = 3'd3;
    #1;
    total++; if (cnd !== 1'b1) begin bad++; $display("FAIL reset_cnd_e got=%b want=1", cnd); end
    ifun = 3'd4;
    #1;
    total++; if (cnd !== 1'b0) begin bad++; $display("FAIL reset_cnd_ne got=%b want=0", cnd); end
    total++; if ({s1_zf, s4_zf, s1_ovalid, s4_ovalid} !== 4'b1100) begin
      bad++; $display("FAIL reset_small got=%b want=1100", {s1_zf, s4_zf, s1_ovalid, s4_ovalid});
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  tc   [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
    logic [63:0] ta   [10] = '{64'd11, 64'd11, 64'd11, 64'd11, -64'd11, -64'd11, 64'd11, 64'd11,
                               64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    logic [63:0] tbv  [10] = '{64'd4, 64'd4, 64'd4, 64'd4, 64'd4, 64'd4, -64'd4, -64'd4, 64'd1, 64'd1};
    logic [63:0] tans [10] = '{64'd15, 64'd7, 64'd0, 64'd15, -64'd7, -64'd15, 64'd7, 64'd15,
                               64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};
    logic        tovf [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        acc;
    logic [3:0]  want_cc;
    logic [3:0]  got_cc;
    exp_t        e;
    got_t        g;
    ifun = 3'd2;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, tc[i], ta[i], tbv[i], 1'b1, 1'b1, acc);
      total++; if (acc !== 1'b1) begin bad++; $display("FAIL b2b_accept op=%0d got=%b want=1", i, acc); end
    end
    for (int k = 0; k < 10 && got_q.size() < 10; k++) step(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 1'b1, acc);
    step(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 1'b1, acc);
    total++; if (got_q.size() != 10) begin bad++; $display("FAIL b2b_count got=%0d want=10", got_q.size()); end
    for (int i = 0; i < 10 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++; if (g.ans !== tans[i] || g.ovf !== tovf[i]) begin
        bad++; $display("FAIL b2b_result op=%0d got=%h/%b want=%h/%b", i, g.ans, g.ovf, tans[i], tovf[i]);
      end
      total++; if (g.cyc - e.cyc != 2) begin
        bad++; $display("FAIL b2b_latency op=%0d got=%0d want=2", i, g.cyc - e.cyc);
      end
      want_cc = {tans[i] == 64'd0, tans[i][63], tovf[i], tans[i][63] ^ tovf[i]};
      got_cc  = {logs[g.cyc+1].zf, logs[g.cyc+1].sf, logs[g.cyc+1].of, logs[g.cyc+1].cnd};
      total++; if (got_cc !== want_cc) begin
        bad++; $display("FAIL b2b_cc op=%0d got zf/sf/of/cnd=%b want=%b", i, got_cc, want_cc);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_backpressure();
    logic [1:0]  bc  [4];
    logic [63:0] ba  [4];
    logic [63:0] bbv [4];
    logic        bsc [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic        acc;
    int          idx;
    int          s;
    exp_t        e;
    got_t        g;
    logic [2:0]  want_cc;
    logic [2:0]  got_cc;
    bc  = '{2'd1, 2'd2, 2'd3, 2'd0};
    ba  = '{64'd3, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
    bbv = '{64'd10, 64'd0, {$urandom, $urandom}, {$urandom, $urandom}};
    idx = 0;
    s   = cyc;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, bc[idx], ba[idx], bbv[idx], bsc[idx], 1'b0, acc);
      if (acc) idx++;
    end
    total++; if (idx != 2) begin bad++; $display("FAIL bp_fill_count got=%0d want=2", idx); end
    total++; if (logs[cyc-1].ir !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", logs[cyc-1].ir); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL bp_no_retire got=%0d want=0", got_q.size()); end
    for (int k = 3; k <= 4; k++) begin
      total++; if (logs[s+k].ov !== 1'b1 || logs[s+k].ans !== logs[s+2].ans || logs[s+k].ovf !== logs[s+2].ovf) begin
        bad++; $display("FAIL bp_stable cycle=%0d got=%b/%h want=1/%h", k, logs[s+k].ov, logs[s+k].ans, logs[s+2].ans);
      end
    end
    for (int k = 0; k < 10 && idx < 4; k++) begin
      step(1'b1, bc[idx], ba[idx], bbv[idx], bsc[idx], 1'b1, acc);
      if (acc) idx++;
    end
    for (int k = 0; k < 10 && got_q.size() < 4; k++) step(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 1'b1, acc);
    step(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 1'b1, acc);
    total++; if (got_q.size() != 4 || exp_q.size() != 4) begin
      bad++; $display("FAIL bp_count got=%0d/%0d want=4/4", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < 4 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++; if (g.ans !== e.ans || g.ovf !== e.ovf) begin
        bad++; $display("FAIL bp_result op=%0d got=%h/%b want=%h/%b", i, g.ans, g.ovf, e.ans, e.ovf);
      end
      got_cc = {logs[g.cyc+1].zf, logs[g.cyc+1].sf, logs[g.cyc+1].of};
      if (e.sc) want_cc = {e.ans == 64'd0, e.ans[63], e.ovf};
      else      want_cc = {logs[g.cyc].zf, logs[g.cyc].sf, logs[g.cyc].of};
      total++; if (got_cc !== want_cc) begin
        bad++; $display("FAIL bp_cc op=%0d set_cc=%b got=%b want=%b", i, e.sc, got_cc, want_cc);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset_midop();
    logic acc;
    int   seen;
    step(1'b1, 2'd1, 64'd0, 64'd5, 1'b1, 1'b1, acc);
    repeat (3) step(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 1'b1, acc);
    total++; if ({zf, sf, of} !== 3'b010) begin bad++; $display("FAIL rst_pre_cc got=%b want=010", {zf, sf, of}); end
    exp_q.delete();
    got_q.delete();
    step(1'b1, 2'd0, 64'd1, 64'd2, 1'b1, 1'b1, acc);
    step(1'b1, 2'd3, 64'd6, 64'd3, 1'b1, 1'b1, acc);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_inflight got=%b want=1", out_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || ans !== 64'd0 || overflow !== 1'b0) begin
      bad++; $display("FAIL rst_async_out got=%b/%h/%b want=0/0/0", out_valid, ans, overflow);
    end
    total++; if ({zf, sf, of} !== 3'b100) begin bad++; $display("FAIL rst_async_cc got=%b want=100", {zf, sf, of}); end
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    @(posedge clk);
    #1;
    exp_q.delete();
    got_q.delete();
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 1'b1, acc);
      if (logs[cyc-1].ov) seen++;
    end
    total++; if (seen != 0 || got_q.size() != 0) begin
      bad++; $display("FAIL rst_stale got=%0d results want=0", seen);
    end
    total++; if ({zf, sf, of} !== 3'b100) begin bad++; $display("FAIL rst_post_cc got=%b want=100", {zf, sf, of}); end
  endtask

  task automatic test_small_stages();
    int         lat1, lat4;
    logic [7:0] a1, a4;
    logic       o1, o4;
    lat1 = -1;
    lat4 = -1;
    a1 = 8'd0; a4 = 8'd0; o1 = 1'b0; o4 = 1'b0;
    sm_valid = 1'b1;
    sm_ctl   = 2'd0;
    sm_a     = 8'd127;
    sm_b     = 8'd1;
    sm_scc   = 1'b1;
    @(negedge clk);
    total++; if ({s1_ready, s4_ready} !== 2'b11) begin bad++; $display("FAIL small_accept got=%b want=11", {s1_ready, s4_ready}); end
    @(posedge clk);
    #1;
    sm_valid = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      if (s1_ovalid && lat1 < 0) begin lat1 = n; a1 = s1_ans; o1 = s1_ovf; end
      if (s4_ovalid && lat4 < 0) begin lat4 = n; a4 = s4_ans; o4 = s4_ovf; end
      @(posedge clk);
      #1;
    end
    total++; if (lat1 != 1) begin bad++; $display("FAIL s1_latency got=%0d want=1", lat1); end
    total++; if (a1 !== 8'h80 || o1 !== 1'b1) begin bad++; $display("FAIL s1_result got=%h/%b want=80/1", a1, o1); end
    total++; if (lat4 != 4) begin bad++; $display("FAIL s4_latency got=%0d want=4", lat4); end
    total++; if (a4 !== 8'h80 || o4 !== 1'b1) begin bad++; $display("FAIL s4_result got=%h/%b want=80/1", a4, o4); end
    total++; if ({s1_zf, s1_sf, s1_of, s4_zf, s4_sf, s4_of} !== 6'b011011) begin
      bad++; $display("FAIL small_cc got=%b want=011011", {s1_zf, s1_sf, s1_of, s4_zf, s4_sf, s4_of});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid  = 1'b0;
    control   = 2'd0;
    a         = '0;
    b         = '0;
    set_cc    = 1'b0;
    out_ready = 1'b1;
    ifun      = 3'd0;
    sm_valid  = 1'b0;
    sm_ordy   = 1'b1;
    sm_scc    = 1'b0;
    sm_ctl    = 2'd0;
    sm_a      = '0;
    sm_b      = '0;
    sm_ifun   = 3'd0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    test_small_stages();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
